// File: rtl/ysyx_25040129_ifu_pkg.sv
// Shared definitions for the ysyx_25040129 instruction fetch unit:
// FSM state encodings, AXI read response codes and the default reset pc.
package ysyx_25040129_ifu_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_ADDR    = 2'd0,
        ST_DATA    = 2'd1,
        ST_SEND    = 2'd2,
        ST_WAIT_WB = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/ysyx_25040129_ifu.sv
// Instruction fetch unit for the multi-cycle ysyx core.
// Fetches one instruction per retirement over AXI4-Lite read, hands it with
// its pc to decode, then waits for the next pc from write-back.
//
// Handshake semantics (all interfaces): a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holding valid keeps its
// payload stable until that edge; valid is never withdrawn before the
// transfer. Ready may change freely while valid is low.
//
// Optional build macro: YSYX_IFU_PERF_EN adds 64-bit perf_fetch_cnt and
// perf_fetch_cyc counter outputs.
//
// state_dbg exposes the current FSM state for checkers.
module ysyx_25040129_ifu
    import ysyx_25040129_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    // AXI4-Lite read
    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    // toward decode
    output logic [31:0]       inst_out_ifu,
    output logic [ADDR_W-1:0] pc_out_ifu,
    output logic              access_fault_out_ifu,
    output logic              is_req_valid_to_idu,
    input  logic              is_req_ready_from_idu,
    // from write-back
    input  logic [ADDR_W-1:0] next_pc_in_ifu,
    input  logic              is_req_valid_from_wbu,
    output logic              is_req_ready_to_wbu,
    // debug
    output logic [1:0]        state_dbg
`ifdef YSYX_IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetch_cnt,
    output logic [63:0]       perf_fetch_cyc
`endif
);

    ifu_state_t        state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic              pending, pending_next;
    logic [ADDR_W-1:0] pending_pc, pending_pc_next;
    logic [31:0]       inst_next;
    logic [ADDR_W-1:0] pc_out_next;
    logic              fault_next;

    logic              ar_hs, r_hs, idu_hs, wbu_hs;
    logic [ADDR_W-1:0] wb_pc_aligned;

    assign ar_hs  = arvalid & arready;
    assign r_hs   = rvalid & rready;
    assign idu_hs = is_req_valid_to_idu & is_req_ready_from_idu;
    assign wbu_hs = is_req_valid_from_wbu & is_req_ready_to_wbu;

    // pc is always word aligned; a misaligned redirect is silently truncated
    assign wb_pc_aligned = {next_pc_in_ifu[ADDR_W-1:2], 2'b00};

    assign araddr    = pc;
    assign state_dbg = state;

    // Next-state, next-pc and fetched-payload selection
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        pending_next    = pending;
        pending_pc_next = pending_pc;
        inst_next       = inst_out_ifu;
        pc_out_next     = pc_out_ifu;
        fault_next      = access_fault_out_ifu;
        case (state)
            ST_ADDR: begin
                if (ar_hs) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (r_hs) begin
                    inst_next   = rdata;
                    pc_out_next = pc;
                    fault_next  = (rresp != AXI_RESP_OKAY);
                    state_next  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (idu_hs) begin
                    if (pending) begin
                        pc_next      = pending_pc;
                        pending_next = 1'b0;
                        state_next   = ST_ADDR;
                    end else if (wbu_hs) begin
                        // retire and decode accept in the same cycle: skip WAIT_WB
                        pc_next    = wb_pc_aligned;
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_WAIT_WB;
                    end
                end else if (wbu_hs) begin
                    // decode still busy: park the next pc until it accepts
                    pending_next    = 1'b1;
                    pending_pc_next = wb_pc_aligned;
                end
            end
            ST_WAIT_WB: begin
                if (wbu_hs) begin
                    pc_next    = wb_pc_aligned;
                    state_next = ST_ADDR;
                end
            end
            default: state_next = ST_ADDR;
        endcase
    end

    // State, pc and registered handshake outputs (outputs follow the next state
    // so they are glitch-free and all deassert during reset)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_ADDR;
            pc                   <= RESET_PC[ADDR_W-1:0];
            pending              <= 1'b0;
            pending_pc           <= RESET_PC[ADDR_W-1:0];
            inst_out_ifu         <= 32'h0;
            pc_out_ifu           <= RESET_PC[ADDR_W-1:0];
            access_fault_out_ifu <= 1'b0;
            arvalid              <= 1'b0;
            rready               <= 1'b0;
            is_req_valid_to_idu  <= 1'b0;
            is_req_ready_to_wbu  <= 1'b0;
        end else begin
            state                <= state_next;
            pc                   <= pc_next;
            pending              <= pending_next;
            pending_pc           <= pending_pc_next;
            inst_out_ifu         <= inst_next;
            pc_out_ifu           <= pc_out_next;
            access_fault_out_ifu <= fault_next;
            arvalid              <= (state_next == ST_ADDR);
            rready               <= (state_next == ST_DATA);
            is_req_valid_to_idu  <= (state_next == ST_SEND);
            is_req_ready_to_wbu  <= (state_next == ST_WAIT_WB) ||
                                    ((state_next == ST_SEND) && !pending_next);
        end
    end

`ifdef YSYX_IFU_PERF_EN
    // Fetch count and cycles spent on the AXI bus (ADDR or DATA)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_cnt <= 64'd0;
            perf_fetch_cyc <= 64'd0;
        end else begin
            if (r_hs) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
            if ((state == ST_ADDR) || (state == ST_DATA))
                perf_fetch_cyc <= perf_fetch_cyc + 64'd1;
        end
    end
`endif

endmodule
